// File: rtl/ln_exp_pkg.sv
// Shared constants and types for the ln/exp datapath: LN2, the ln(1+2^-i) table,
// a fraction-slicing helper and the iterative ln FSM state type.
package ln_exp_pkg;

  typedef enum logic [1:0] {StIdle, StNorm, StIter, StDone} ln_state_e;

  // ln(2) as a 64-bit fraction.
  localparam logic [63:0] LN2 = 64'hB17217F7D1CF79AB;

  // ln(1+2^-i) as a 64-bit fraction, from the alternating series evaluated with 96
  // fraction bits and then truncated; entry 0 is ln(2).
  function automatic logic [63:0] lnp_calc(input int unsigned i);
    logic [127:0] sum;
    logic [127:0] term;
    if (i == 0) return LN2;
    sum = '0;
    for (int unsigned k = 1; k * i <= 96; k++) begin
      term = (128'd1 << (96 - k * i)) / 128'(k);
      if (k[0]) sum = sum + term;
      else      sum = sum - term;
    end
    return 64'(sum >> 32);
  endfunction

  function automatic logic [63:0][63:0] lnp_table();
    logic [63:0][63:0] t;
    for (int unsigned k = 0; k < 64; k++) t[k] = lnp_calc(k);
    return t;
  endfunction

  localparam logic [63:0][63:0] LNP = lnp_table();

  // Keep the top n fraction bits of a 64-bit fraction (truncation).
  function automatic logic [63:0] frac_slice(input logic [63:0] c, input int unsigned n);
    return c >> (64 - n);
  endfunction

endpackage

// File: rtl/lzd_norm.sv
// Leading-one detector plus barrel normaliser: shifts the operand so its leading one
// lands in the MSB and reports that one's original bit index.
module lzd_norm #(
  parameter int unsigned Width = 32,
  localparam int unsigned PosW = $clog2(Width)
) (
  input  logic [Width-1:0] x_i,
  output logic [PosW-1:0]  pos_o,
  output logic             zero_o,
  output logic [Width-1:0] norm_o
);

  logic [PosW-1:0] shamt;

  always_comb begin
    pos_o = '0;
    for (int k = 0; k < Width; k++) begin
      if (x_i[k]) pos_o = k[PosW-1:0];
    end
    zero_o = (x_i == '0);
    shamt  = PosW'(Width - 1) - pos_o;
    norm_o = x_i << shamt;
  end

endmodule

// File: rtl/ln_iterative.sv
// Iterative natural log by shift-and-add multiplicative normalisation, one iteration per
// clock. Define LN_ROUND_EN to round (half-up) instead of truncating the guard bits.
module ln_iterative
  import ln_exp_pkg::*;
#(
  parameter int unsigned IN_HIGH  = 16,
  parameter int unsigned IN_LOW   = 16,
  parameter int unsigned OUT_HIGH = 5,
  parameter int unsigned OUT_LOW  = 16,
  parameter int unsigned GUARD    = 4,
  parameter int unsigned ITERS    = OUT_LOW + GUARD
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_HIGH+IN_LOW-1:0]     in_x,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_HIGH+OUT_LOW-1:0]   out_ln,
  output logic                          out_err
);

  localparam int unsigned W     = IN_HIGH + IN_LOW;
  localparam int unsigned OutW  = OUT_HIGH + OUT_LOW;
  localparam int unsigned AF    = OUT_LOW + GUARD;
  localparam int unsigned PW    = $clog2(W);
  localparam int unsigned EW    = PW + 2;
  localparam int unsigned ZW    = W + GUARD + 1;
  localparam int unsigned IW    = $clog2(ITERS + 1);
  localparam int unsigned ProdW = EW + 65;
  localparam int unsigned AccA  = EW + AF + 1;
  localparam int unsigned AccB  = OutW + GUARD + 1;
  localparam int unsigned AccW  = (AccA > AccB) ? AccA : AccB;

  localparam logic [ZW-1:0]          ZOne    = {1'b1, {(ZW-1){1'b0}}};
  localparam logic signed [AccW-1:0] OutMax  = (AccW'(1) << (OutW - 1)) - AccW'(1);
  localparam logic signed [AccW-1:0] OutMin  = ~OutMax;
  localparam logic signed [AccW-1:0] AccHalf = AccW'(1) << (GUARD - 1);

  ln_state_e               state_q, state_d;
  logic [W-1:0]            x_q, x_d;
  logic [ZW-1:0]           z_q, z_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [IW-1:0]           i_q, i_d;
  logic                    err_q, err_d;

  logic [PW-1:0]           pos_w;
  logic                    zero_w;
  logic [W-1:0]            norm_w;
  logic [EW-1:0]           e_w;
  logic signed [ProdW-1:0] eln2_w;
  logic signed [AccW-1:0]  acc_init_w;
  logic signed [AccW-1:0]  lnp_w;
  logic [ZW-1:0]           t_w;
  logic signed [AccW-1:0]  acc_adj;
  logic signed [AccW-1:0]  acc_sh;

  lzd_norm #(
    .Width (W)
  ) u_lzd_norm (
    .x_i    (x_q),
    .pos_o  (pos_w),
    .zero_o (zero_w),
    .norm_o (norm_w)
  );

  // Exponent of the power-of-two split: x = 2^e * m with m in [0.5, 1).
  assign e_w        = EW'(pos_w) - EW'(IN_LOW - 1);
  // e*ln2 from the full 64-bit constant so the error stays below one accumulator LSB.
  assign eln2_w     = $signed({{(ProdW-EW){e_w[EW-1]}}, e_w}) *
                      $signed({{(ProdW-64){1'b0}}, LN2});
  assign acc_init_w = AccW'(eln2_w >>> (64 - AF));
  assign lnp_w      = AccW'(frac_slice(LNP[i_q], AF));
  assign t_w        = z_q + (z_q >> i_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    z_d     = z_q;
    acc_d   = acc_q;
    i_d     = i_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          err_d   = 1'b0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (zero_w) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          z_d     = {1'b0, norm_w, {GUARD{1'b0}}};
          acc_d   = acc_init_w;
          i_d     = IW'(1);
          state_d = StIter;
        end
      end
      StIter: begin
        if (t_w <= ZOne) begin
          z_d   = t_w;
          acc_d = acc_q - lnp_w;
        end
        if (i_q == IW'(ITERS)) state_d = StDone;
        else                   i_d = i_q + IW'(1);
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
`ifdef LN_ROUND_EN
    acc_adj = acc_q + AccHalf;
`else
    acc_adj = acc_q;
`endif
    acc_sh = acc_adj >>> GUARD;
    out_ln = '0;
    if (state_q == StDone) begin
      if (err_q)                 out_ln = {1'b1, {(OutW-1){1'b0}}};
      else if (acc_sh > OutMax)  out_ln = OutW'(OutMax);
      else if (acc_sh < OutMin)  out_ln = OutW'(OutMin);
      else                       out_ln = OutW'(acc_sh);
    end
  end

  // Gated by rst_n so the source never sees ready while the unit is held in reset.
  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = (state_q == StDone);
  assign out_err   = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_ln_iterative.sv
// Self-checking bench for ln_iterative: directed corner cases plus random operands
// compared against a real-valued ln() reference.
module tb_ln_iterative;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_ln;
  logic        out_err;

  int n_checks;
  int n_pass;

  ln_iterative u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ln    (out_ln),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, got, exp, tol);
  endtask

  // ln of the Q16.16 operand expressed in output LSBs (2^-16).
  function automatic longint ref_ln(input longint unsigned x);
    real r;
    r = $ln(real'(x) / 65536.0) * 65536.0;
`ifdef LN_ROUND_EN
    return longint'($floor(r + 0.5));
`else
    return longint'($floor(r));
`endif
  endfunction

  // Caller sits #1 after a rising edge. lat counts edges from accept to out_valid.
  task automatic run_op(input logic [31:0] x, output longint ln, output longint err,
                        output longint lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) check("ready_timeout", 0, 1);
    in_x     = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check("result_timeout", 0, 1);
    ln  = longint'($signed(out_ln));
    err = longint'(out_err);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    longint ln, err, lat, first_ln;
    int     cnt, first, second;
    logic [31:0] x;

    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;

    #23;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_ln", longint'(out_ln), 0);
    check("rst_out_err", longint'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", longint'(in_ready), 1);

    run_op(32'h0001_0000, ln, err, lat);
    check("one_ln", ln, 0, 1);
    check("one_err", err, 0);
    check("one_latency", lat, 22);

    run_op(32'h0002_0000, ln, err, lat);
    check("two_ln", ln, 64'sh0B172, 1);
    run_op(32'h0002_B7E1, ln, err, lat);
    check("e_ln", ln, 64'sh10000, 2);
    run_op(32'h0000_0001, ln, err, lat);
    check("min_ln", ln, -726817, 2);
    run_op(32'hFFFF_FFFF, ln, err, lat);
    check("max_ln", ln, 726817, 2);
    check("max_err", err, 0);

    run_op(32'h0000_0000, ln, err, lat);
    check("zero_err", err, 1);
    check("zero_ln", ln, -(64'sd1 << 20));
    check("zero_latency", lat, 2);

    // Back-pressure: result must hold while the consumer stalls; extra operands ignored.
    out_ready = 1'b0;
    run_op(32'h0003_0000, first_ln, err, lat);
    check("bp_ln", first_ln, ref_ln(64'h0003_0000), 2);
    in_x     = 32'h0000_0100;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold_ln", longint'($signed(out_ln)), first_ln);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_out_valid", longint'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", longint'(in_ready), 1);
    check("bp_release_valid", longint'(out_valid), 0);

    // Throughput with in_valid held and out_ready high.
    in_x     = 32'h0001_0000;
    in_valid = 1'b1;
    cnt      = 0;
    first    = -1;
    second   = -1;
    while (cnt < 100 && second < 0) begin
      if (in_ready) begin
        if (first < 0) first = cnt;
        else second = cnt;
      end
      if (second < 0) begin
        @(posedge clk); #1; cnt++;
      end
    end
    in_valid = 1'b0;
    check("throughput", longint'(second - first), 23);

    // Reset in the middle of the iterations.
    run_op(32'h1234_5678, ln, err, lat);
    in_x     = 32'h0000_ABCD;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_iter_valid", longint'(out_valid), 0);
    check("rst_iter_ready", longint'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while holding a result must drop out_valid without waiting for a clock.
    out_ready = 1'b0;
    run_op(32'h0000_8000, ln, err, lat);
    check("pre_rst_valid", longint'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", longint'(out_valid), 0);
    check("rst_done_ln", longint'(out_ln), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_op(32'h0001_0000, ln, err, lat);
    check("post_rst_ln", ln, 0, 1);
    check("post_rst_latency", lat, 22);

    for (int n = 0; n < 300; n++) begin
      x = $urandom >> $urandom_range(0, 31);
      if (x == 0) x = 32'd1;
      run_op(x, ln, err, lat);
      check("rand_ln", ln, ref_ln(longint'(x)), 2);
      check("rand_err", err, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
